snake_game_sequencer: RTL and testbench
=======================================

// Module: snake_game_sequencer
// PURPOSE
//  Game controller between the debouncers/ClockDivider and the snake body datapath.
//  Owns the DEAD/PLAY/PAUSE FSM and latches direction. Per game tick it computes the next head,
//  checks walls, self-hit and food, then issues one step (move or grow) to the datapath.
//  Also keeps the 4-digit BCD score shown by the 7-seg controller.
// PARAMETERS
//  GRID_WIDTH   32  columns; XW = $clog2(GRID_WIDTH)
//  GRID_HEIGHT  24  rows;    YW = $clog2(GRID_HEIGHT)
//  WALL_WRAP    0   1: head wraps at edges; 0: leaving grid kills
// PORTS
//  Clock         in   1   system clock (ClockDivider Clock domain)
//  ResetN        in   1   synchronous, active-low reset
//  GameTick      in   1   1-cycle pulse per game step
//  LeftPressed, RightPressed, UpPressed, DownPressed, CenterPressed  in  1 each  debounced 1-cycle pulses
//  HeadX/HeadY   in   XW/YW  current head from datapath
//  FoodX/FoodY   in   XW/YW  current food position
//  BodyHit       in   1   datapath: NextX/NextY lies on the body, excluding the tail cell; valid 1 cycle after Next* stable
//  StepAck       in   1   datapath finished step/clear
//  State         out  2   `STATE_DEAD/`STATE_PAUSE/`STATE_PLAY
//  Dir           out  2   committed `DIR_*
//  NextX/NextY   out  XW/YW  candidate head
//  StepReq       out  1   level; held until StepAck
//  StepGrow      out  1   qualifies StepReq: 1 = grow (keep tail)
//  ClearReq      out  1   level; reinit body; held until StepAck
//  FoodReq       out  1   1-cycle pulse: randomizer must place new food
//  ScoreBcd      out  16  {thousands,hundreds,tens,ones}
//  SegEnable     out  1   1 unless State==DEAD and score==0
// BEHAVIOUR
//  Reset values: FSM=S_DEAD, State=DEAD, Dir=pendDir=`DIR_RIGHT, Next*=0, StepReq=StepGrow=ClearReq=FoodReq=0,
//    ScoreBcd=0, SegEnable=0. ResetN low mid-handshake drops all requests the same cycle.
//  FSM: S_DEAD -Center-> S_INIT (ClearReq=1, score=0, Dir=RIGHT) -StepAck-> S_WAIT.
//   S_WAIT: Center -> S_PAUSE; else GameTick -> S_CALC.
//   S_CALC (1 cycle): Dir<=pendDir; Next=Head+/-1 on the axis. WALL_WRAP=0: edge crossing -> S_DEAD.
//     WALL_WRAP=1: 0-1 -> GRID-1, GRID-1+1 -> 0 (not a power-of-2 wrap).
//   S_CHECK (1 cycle): BodyHit -> S_DEAD; else StepGrow=(Next==Food), StepReq=1 -> S_STEP.
//   S_STEP: hold Next*, StepReq, StepGrow until StepAck. Then drop both; if grow, FoodReq pulse and score+1 -> S_WAIT.
//   S_PAUSE: Center -> S_WAIT; arrow presses ignored.
//  GameTick outside S_WAIT is dropped, not queued. Center outside S_DEAD/S_WAIT/S_PAUSE is ignored.
//  Center and GameTick in the same S_WAIT cycle: pause wins.
//  Direction: an arrow pulse updates pendDir in S_WAIT/S_CALC*; reversal of committed Dir is ignored.
//    Same-cycle priority: Up>Down>Left>Right. Last accepted press before S_CALC wins.
//  Score: BCD ripple increment; saturates at 9999; kept through DEAD, cleared in S_INIT.
//  Latency: tick -> StepReq = 2 cycles (S_CALC, S_CHECK).
// STRUCTURE
//  Constants.v (shared): STATE_*, DIR_*, BITS_PER_DIR, GRID_WIDTH/HEIGHT, local FSM encodings S_*.
//  Sub-module: bcd_score_counter (4 digits, inc, clr, saturate at 9999).
// TESTING
//  1 Reset, Center, StepAck -> State=PLAY, Dir=RIGHT, ClearReq seen exactly once, score 0000.
//  2 Head(5,5), Food(7,9), tick -> 2 cycles later StepReq, Next=(6,5), StepGrow=0; ack -> FoodReq stays 0.
//  3 Head(6,5), Food(7,5), tick, ack -> StepGrow=1, FoodReq one pulse, ScoreBcd 0x0001; 9999+1 stays 0x9999.
//  4 Dir=RIGHT, Left press -> Dir unchanged; Up+Left same cycle -> Dir=UP at next tick.
//  5 Head(31,3), RIGHT, tick: WALL_WRAP=0 -> State=DEAD, no StepReq; WALL_WRAP=1 -> Next=(0,3).
//  6 BodyHit=1 in S_CHECK -> DEAD. Center+tick same cycle -> PAUSE, no step.
//    Tick during S_STEP dropped. ResetN low in S_STEP -> StepReq=0 next cycle.

Source files
------------

// File: rtl/snake_game_sequencer_pkg.sv
// Shared constants for the snake game controller: public state/direction codes,
// grid defaults, the internal FSM encoding and a direction helper.
package snake_game_sequencer_pkg;

    localparam int BITS_PER_DIR = 2;
    localparam int DEF_GRID_WIDTH  = 32;
    localparam int DEF_GRID_HEIGHT = 24;

    localparam logic [1:0] STATE_DEAD  = 2'd0;
    localparam logic [1:0] STATE_PLAY  = 2'd1;
    localparam logic [1:0] STATE_PAUSE = 2'd2;

    // Opposite directions share bit 1 and differ only in bit 0.
    localparam logic [BITS_PER_DIR-1:0] DIR_UP    = 2'd0;
    localparam logic [BITS_PER_DIR-1:0] DIR_DOWN  = 2'd1;
    localparam logic [BITS_PER_DIR-1:0] DIR_LEFT  = 2'd2;
    localparam logic [BITS_PER_DIR-1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_DEAD  = 3'd0,
        S_INIT  = 3'd1,
        S_WAIT  = 3'd2,
        S_CALC  = 3'd3,
        S_CHECK = 3'd4,
        S_STEP  = 3'd5,
        S_PAUSE = 3'd6
    } fsm_state_e;

    function automatic logic is_reverse(input logic [BITS_PER_DIR-1:0] a,
                                        input logic [BITS_PER_DIR-1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_game_sequencer_bcd_score_counter.sv
// Four-digit BCD score: synchronous clear, ripple increment, sticks at 9999.
module bcd_score_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] score
);

    logic [15:0] score_q, score_d;
    logic        carry;
    logic [3:0]  digit;

    always_comb begin
        score_d = score_q;
        carry   = 1'b1;
        digit   = 4'd0;
        if (clr) begin
            score_d = 16'h0000;
        end else if (inc && (score_q != 16'h9999)) begin
            for (int i = 0; i < 4; i++) begin
                digit = score_q[4*i +: 4];
                if (carry) begin
                    if (digit == 4'd9) begin
                        score_d[4*i +: 4] = 4'd0;
                    end else begin
                        score_d[4*i +: 4] = digit + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) score_q <= 16'h0000;
        else        score_q <= score_d;
    end

    assign score = score_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Game controller: DEAD/PLAY/PAUSE sequencing, direction latching, next-head
// computation and the move/grow/clear handshakes towards the body datapath.
module snake_game_sequencer
    import snake_game_sequencer_pkg::*;
#(
    parameter int  GRID_WIDTH  = DEF_GRID_WIDTH,
    parameter int  GRID_HEIGHT = DEF_GRID_HEIGHT,
    parameter int  WALL_WRAP   = 0,
    localparam int XW = $clog2(GRID_WIDTH),
    localparam int YW = $clog2(GRID_HEIGHT)
) (
    input  logic          Clock,
    input  logic          ResetN,
    input  logic          GameTick,
    input  logic          LeftPressed,
    input  logic          RightPressed,
    input  logic          UpPressed,
    input  logic          DownPressed,
    input  logic          CenterPressed,
    input  logic [XW-1:0] HeadX,
    input  logic [YW-1:0] HeadY,
    input  logic [XW-1:0] FoodX,
    input  logic [YW-1:0] FoodY,
    input  logic          BodyHit,
    input  logic          StepAck,
    output logic [1:0]    State,
    output logic [1:0]    Dir,
    output logic [XW-1:0] NextX,
    output logic [YW-1:0] NextY,
    output logic          StepReq,
    output logic          StepGrow,
    output logic          ClearReq,
    output logic          FoodReq,
    output logic [15:0]   ScoreBcd,
    output logic          SegEnable,
    output logic [2:0]    DbgFsmState
);

    fsm_state_e fsm_q, fsm_d;
    logic [1:0] state_q, state_d;
    logic [BITS_PER_DIR-1:0] dir_q, dir_d, pend_dir_q, pend_dir_d;
    logic [BITS_PER_DIR-1:0] arrow_dir, ref_dir;
    logic       arrow_any;
    logic [XW-1:0] next_x_q, next_x_d, cand_x;
    logic [YW-1:0] next_y_q, next_y_d, cand_y;
    logic       wall_hit;
    logic       step_req_q, step_req_d, step_grow_q, step_grow_d;
    logic       clear_req_q, clear_req_d, food_req_q, food_req_d;
    logic       score_inc, score_clr;
    logic [15:0] score;

    // Candidate head one cell along the pending direction, with edge detection.
    always_comb begin
        cand_x   = HeadX;
        cand_y   = HeadY;
        wall_hit = 1'b0;
        case (pend_dir_q)
            DIR_UP: begin
                if (HeadY == '0) begin wall_hit = 1'b1; cand_y = YW'(GRID_HEIGHT - 1); end
                else cand_y = HeadY - YW'(1);
            end
            DIR_DOWN: begin
                if (HeadY == YW'(GRID_HEIGHT - 1)) begin wall_hit = 1'b1; cand_y = '0; end
                else cand_y = HeadY + YW'(1);
            end
            DIR_LEFT: begin
                if (HeadX == '0) begin wall_hit = 1'b1; cand_x = XW'(GRID_WIDTH - 1); end
                else cand_x = HeadX - XW'(1);
            end
            default: begin
                if (HeadX == XW'(GRID_WIDTH - 1)) begin wall_hit = 1'b1; cand_x = '0; end
                else cand_x = HeadX + XW'(1);
            end
        endcase
    end

    // Step/clear handshake: the request is a level that stays asserted with its
    // qualifiers stable until the datapath answers with a one-cycle StepAck.
    always_comb begin
        fsm_d       = fsm_q;
        dir_d       = dir_q;
        pend_dir_d  = pend_dir_q;
        next_x_d    = next_x_q;
        next_y_d    = next_y_q;
        step_req_d  = step_req_q;
        step_grow_d = step_grow_q;
        clear_req_d = clear_req_q;
        food_req_d  = 1'b0;
        state_d     = state_q;

        arrow_any = UpPressed | DownPressed | LeftPressed | RightPressed;
        if (UpPressed)        arrow_dir = DIR_UP;
        else if (DownPressed) arrow_dir = DIR_DOWN;
        else if (LeftPressed) arrow_dir = DIR_LEFT;
        else                  arrow_dir = DIR_RIGHT;
        ref_dir = (fsm_q == S_CALC) ? pend_dir_q : dir_q;
        if (arrow_any && (fsm_q == S_WAIT || fsm_q == S_CALC) && !is_reverse(arrow_dir, ref_dir))
            pend_dir_d = arrow_dir;

        case (fsm_q)
            S_DEAD: if (CenterPressed) begin
                fsm_d       = S_INIT;
                clear_req_d = 1'b1;
                dir_d       = DIR_RIGHT;
                pend_dir_d  = DIR_RIGHT;
            end
            S_INIT: if (StepAck) begin
                clear_req_d = 1'b0;
                fsm_d       = S_WAIT;
            end
            S_WAIT: begin
                if (CenterPressed)  fsm_d = S_PAUSE;
                else if (GameTick)  fsm_d = S_CALC;
            end
            S_CALC: begin
                dir_d = pend_dir_q;
                if (wall_hit && (WALL_WRAP == 0)) begin
                    fsm_d = S_DEAD;
                end else begin
                    next_x_d = cand_x;
                    next_y_d = cand_y;
                    fsm_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (BodyHit) begin
                    fsm_d = S_DEAD;
                end else begin
                    step_req_d  = 1'b1;
                    step_grow_d = (next_x_q == FoodX) && (next_y_q == FoodY);
                    fsm_d       = S_STEP;
                end
            end
            S_STEP: if (StepAck) begin
                step_req_d  = 1'b0;
                step_grow_d = 1'b0;
                food_req_d  = step_grow_q;
                fsm_d       = S_WAIT;
            end
            S_PAUSE: if (CenterPressed) fsm_d = S_WAIT;
            default: fsm_d = S_DEAD;
        endcase

        case (fsm_d)
            S_DEAD:  state_d = STATE_DEAD;
            S_PAUSE: state_d = STATE_PAUSE;
            default: state_d = STATE_PLAY;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            fsm_q       <= S_DEAD;
            state_q     <= STATE_DEAD;
            dir_q       <= DIR_RIGHT;
            pend_dir_q  <= DIR_RIGHT;
            next_x_q    <= '0;
            next_y_q    <= '0;
            step_req_q  <= 1'b0;
            step_grow_q <= 1'b0;
            clear_req_q <= 1'b0;
            food_req_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_dir_q  <= pend_dir_d;
            next_x_q    <= next_x_d;
            next_y_q    <= next_y_d;
            step_req_q  <= step_req_d;
            step_grow_q <= step_grow_d;
            clear_req_q <= clear_req_d;
            food_req_q  <= food_req_d;
        end
    end

    assign score_inc = (fsm_q == S_STEP) && StepAck && step_grow_q;
    assign score_clr = (fsm_q == S_DEAD) && CenterPressed;

    bcd_score_counter u_score (
        .clk   (Clock),
        .rst_n (ResetN),
        .clr   (score_clr),
        .inc   (score_inc),
        .score (score)
    );

    // Requests are gated by ResetN so an abort is visible before the reset edge.
    assign StepReq     = step_req_q & ResetN;
    assign ClearReq    = clear_req_q & ResetN;
    assign FoodReq     = food_req_q & ResetN;
    assign StepGrow    = step_grow_q;
    assign State       = state_q;
    assign Dir         = dir_q;
    assign NextX       = next_x_q;
    assign NextY       = next_y_q;
    assign ScoreBcd    = score;
    assign SegEnable   = !((state_q == STATE_DEAD) && (score == 16'h0000));
    assign DbgFsmState = fsm_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer (no-wrap and wrap instances) and the BCD score counter.
module tb_snake_game_sequencer;
  import snake_game_sequencer_pkg::*;

  localparam int XW = 5;
  localparam int YW = 5;

  logic Clock = 1'b0;
  logic ResetN, GameTick, LeftPressed, RightPressed, UpPressed, DownPressed, CenterPressed;
  logic BodyHit, StepAck;
  logic [XW-1:0] HeadX, FoodX;
  logic [YW-1:0] HeadY, FoodY;

  logic [1:0] state, dir, w_state, w_dir;
  logic [XW-1:0] next_x, w_next_x;
  logic [YW-1:0] next_y, w_next_y;
  logic step_req, step_grow, clear_req, food_req, seg_en;
  logic w_step_req, w_step_grow, w_clear_req, w_food_req, w_seg_en;
  logic [15:0] score, w_score;
  logic [2:0] dbg, w_dbg;

  logic b_rst_n, b_clr, b_inc;
  logic [15:0] b_score;

  logic [XW+YW:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int food_cnt = 0;
  int clr_rise = 0;
  logic clr_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  snake_game_sequencer #(.GRID_WIDTH(32), .GRID_HEIGHT(24), .WALL_WRAP(0)) dut (
    .Clock(Clock), .ResetN(ResetN), .GameTick(GameTick),
    .LeftPressed(LeftPressed), .RightPressed(RightPressed), .UpPressed(UpPressed),
    .DownPressed(DownPressed), .CenterPressed(CenterPressed),
    .HeadX(HeadX), .HeadY(HeadY), .FoodX(FoodX), .FoodY(FoodY),
    .BodyHit(BodyHit), .StepAck(StepAck),
    .State(state), .Dir(dir), .NextX(next_x), .NextY(next_y),
    .StepReq(step_req), .StepGrow(step_grow), .ClearReq(clear_req), .FoodReq(food_req),
    .ScoreBcd(score), .SegEnable(seg_en), .DbgFsmState(dbg)
  );

  snake_game_sequencer #(.GRID_WIDTH(32), .GRID_HEIGHT(24), .WALL_WRAP(1)) dut_wrap (
    .Clock(Clock), .ResetN(ResetN), .GameTick(GameTick),
    .LeftPressed(LeftPressed), .RightPressed(RightPressed), .UpPressed(UpPressed),
    .DownPressed(DownPressed), .CenterPressed(CenterPressed),
    .HeadX(HeadX), .HeadY(HeadY), .FoodX(FoodX), .FoodY(FoodY),
    .BodyHit(BodyHit), .StepAck(StepAck),
    .State(w_state), .Dir(w_dir), .NextX(w_next_x), .NextY(w_next_y),
    .StepReq(w_step_req), .StepGrow(w_step_grow), .ClearReq(w_clear_req), .FoodReq(w_food_req),
    .ScoreBcd(w_score), .SegEnable(w_seg_en), .DbgFsmState(w_dbg)
  );

  bcd_score_counter u_bcd (
    .clk(Clock), .rst_n(b_rst_n), .clr(b_clr), .inc(b_inc), .score(b_score)
  );

  always @(posedge Clock) begin
    if (food_req) food_cnt++;
    if (clear_req && !clr_prev) clr_rise++;
    clr_prev = clear_req;
  end

  // ---------------- driver tasks ----------------
  task automatic tick_clk();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_center();
    CenterPressed = 1'b1;
    tick_clk();
    CenterPressed = 1'b0;
  endtask

  task automatic ack();
    StepAck = 1'b1;
    tick_clk();
    StepAck = 1'b0;
  endtask

  task automatic send_tick(input logic grow, input logic [XW-1:0] ex, input logic [YW-1:0] ey);
    exp_q.push_back({grow, ex, ey});
    GameTick = 1'b1;
    tick_clk();
    GameTick = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic wait_step(input string tag);
    int cyc = 0;
    logic [XW+YW:0] e;
    while (!step_req && cyc < 8) begin
      tick_clk();
      cyc++;
    end
    chk({tag, "_req"}, {31'd0, step_req}, 32'd1);
    chk({tag, "_lat"}, cyc, 32'd2);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_step"}, {21'd0, step_grow, next_x, next_y}, {21'd0, e});
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int model;
    logic [XW+YW:0] e;
    ResetN = 1'b0; GameTick = 1'b0; BodyHit = 1'b0; StepAck = 1'b0;
    LeftPressed = 1'b0; RightPressed = 1'b0; UpPressed = 1'b0; DownPressed = 1'b0;
    CenterPressed = 1'b0;
    HeadX = 5'd5; HeadY = 5'd5; FoodX = 5'd7; FoodY = 5'd9;
    b_rst_n = 1'b0; b_clr = 1'b0; b_inc = 1'b0;
    tick_clk();
    tick_clk();

    chk("rst_state", state, STATE_DEAD);
    chk("rst_dir", dir, DIR_RIGHT);
    chk("rst_next", {next_x, next_y}, 0);
    chk("rst_reqs", {step_req, step_grow, clear_req, food_req}, 0);
    chk("rst_score", score, 0);
    chk("rst_seg", seg_en, 0);
    ResetN = 1'b1;
    b_rst_n = 1'b1;
    tick_clk();

    // start a game
    pulse_center();
    chk("init_clear", clear_req, 1);
    tick_clk();
    tick_clk();
    chk("init_clear_held", clear_req, 1);
    ack();
    chk("play_state", state, STATE_PLAY);
    chk("play_dir", dir, DIR_RIGHT);
    chk("play_score", score, 0);
    chk("play_clear_drop", clear_req, 0);
    chk("clear_once", clr_rise, 1);
    chk("play_seg", seg_en, 1);

    // plain move
    send_tick(1'b0, 5'd6, 5'd5);
    wait_step("move");
    ack();
    chk("move_req_drop", step_req, 0);
    chk("move_food", food_req, 0);
    tick_clk();
    chk("move_food_cnt", food_cnt, 0);

    // grow onto food
    HeadX = 5'd6; HeadY = 5'd5; FoodX = 5'd7; FoodY = 5'd5;
    send_tick(1'b1, 5'd7, 5'd5);
    wait_step("grow");
    ack();
    chk("grow_food_pulse", food_req, 1);
    chk("grow_score", score, 16'h0001);
    tick_clk();
    chk("grow_food_end", food_req, 0);
    chk("grow_food_cnt", food_cnt, 1);

    // reversal ignored
    FoodX = 5'd0; FoodY = 5'd0;
    LeftPressed = 1'b1; tick_clk(); LeftPressed = 1'b0;
    HeadX = 5'd7; HeadY = 5'd5;
    send_tick(1'b0, 5'd8, 5'd5);
    wait_step("reverse");
    chk("reverse_dir", dir, DIR_RIGHT);
    ack();

    // Up beats Left in the same cycle
    UpPressed = 1'b1; LeftPressed = 1'b1; tick_clk(); UpPressed = 1'b0; LeftPressed = 1'b0;
    HeadX = 5'd8; HeadY = 5'd5;
    send_tick(1'b0, 5'd8, 5'd4);
    wait_step("prio");
    chk("prio_dir", dir, DIR_UP);
    ack();

    // last accepted press wins
    LeftPressed = 1'b1; tick_clk(); LeftPressed = 1'b0;
    RightPressed = 1'b1; tick_clk(); RightPressed = 1'b0;
    HeadX = 5'd8; HeadY = 5'd4;
    send_tick(1'b0, 5'd9, 5'd4);
    wait_step("last");
    chk("last_dir", dir, DIR_RIGHT);

    // tick while a step is outstanding is dropped
    GameTick = 1'b1; tick_clk(); GameTick = 1'b0;
    ack();
    repeat (4) tick_clk();
    chk("drop_tick", step_req, 0);
    chk("drop_sb", exp_q.size(), 0);

    // pause beats tick
    CenterPressed = 1'b1; GameTick = 1'b1; tick_clk(); CenterPressed = 1'b0; GameTick = 1'b0;
    chk("pause_state", state, STATE_PAUSE);
    GameTick = 1'b1; UpPressed = 1'b1; tick_clk(); GameTick = 1'b0; UpPressed = 1'b0;
    repeat (3) tick_clk();
    chk("pause_no_step", step_req, 0);
    pulse_center();
    chk("resume_state", state, STATE_PLAY);
    HeadX = 5'd10; HeadY = 5'd4;
    send_tick(1'b0, 5'd11, 5'd4);
    wait_step("resume");
    ack();

    // body hit kills
    HeadX = 5'd11; HeadY = 5'd4;
    GameTick = 1'b1; tick_clk(); GameTick = 1'b0;
    tick_clk();
    BodyHit = 1'b1; tick_clk(); BodyHit = 1'b0;
    chk("hit_state", state, STATE_DEAD);
    chk("hit_no_step", step_req, 0);
    chk("hit_score_kept", score, 16'h0001);
    chk("hit_seg", seg_en, 1);

    // restart, then run into the right wall
    pulse_center();
    chk("restart_score", score, 0);
    chk("restart_clear", clear_req, 1);
    ack();
    HeadX = 5'd31; HeadY = 5'd3;
    send_tick(1'b0, 5'd0, 5'd3);
    tick_clk();
    chk("wall_dead", state, STATE_DEAD);
    chk("wrap_alive", w_state, STATE_PLAY);
    tick_clk();
    chk("wall_no_step", step_req, 0);
    chk("wall_seg", seg_en, 0);
    chk("wrap_req", w_step_req, 1);
    if (exp_q.size() == 0) begin
      chk("wrap_sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("wrap_step", {21'd0, w_step_grow, w_next_x, w_next_y}, {21'd0, e});
    end

    // reset mid-handshake
    ResetN = 1'b0;
    #1;
    chk("abort_same_cycle", w_step_req, 0);
    tick_clk();
    chk("abort_req", w_step_req, 0);
    chk("abort_state", w_state, STATE_DEAD);
    ResetN = 1'b1;

    // BCD counter ripple and saturation against an integer model
    model = 0;
    tick_clk();
    chk("bcd_rst", b_score, 16'h0000);
    b_inc = 1'b1;
    repeat (10) begin tick_clk(); model++; end
    chk("bcd_10", b_score, to_bcd(model));
    repeat (90) begin tick_clk(); model++; end
    chk("bcd_100", b_score, to_bcd(model));
    repeat (899) begin tick_clk(); model++; end
    chk("bcd_999", b_score, to_bcd(model));
    repeat (9000) begin tick_clk(); model++; end
    chk("bcd_9999", b_score, to_bcd(model));
    tick_clk();
    chk("bcd_sat", b_score, 16'h9999);
    b_inc = 1'b0;
    b_clr = 1'b1; tick_clk(); b_clr = 1'b0;
    chk("bcd_clr", b_score, 16'h0000);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
